alu_core: RTL and testbench

//   64-bit integer ALU for the pipelined AArch64 core execute stage.

---
 rtl/alu_core.sv | 81 ++++++++
 tb/tb_alu_core.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Execute-stage integer ALU: pass-B, add, sub, and, or, xor on two WIDTH-bit operands.
// Result and NZVC flags are computed combinationally and captured in output registers.
module alu_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] low_sum;
  logic             carry_into_msb;
  logic [1:0]       msb_sum;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
  logic [WIDTH-1:0] result_d;
  logic             overflow_d;
  logic             carry_d;

  assign is_sub   = (cntrl == OP_SUB);
  assign is_arith = (cntrl == OP_ADD) || (cntrl == OP_SUB);
  assign b_op     = is_sub ? ~B : B;

  // The adder is split at the MSB so the carry into bit WIDTH-1 is visible for overflow.
  assign low_sum        = {1'b0, A[WIDTH-2:0]} + {1'b0, b_op[WIDTH-2:0]}
                        + {{(WIDTH-1){1'b0}}, is_sub};
  assign carry_into_msb = low_sum[WIDTH-1];
  assign msb_sum        = {1'b0, A[WIDTH-1]} + {1'b0, b_op[WIDTH-1]} + {1'b0, carry_into_msb};
  assign sum            = {msb_sum[0], low_sum[WIDTH-2:0]};
  assign sum_carry      = msb_sum[1];

  always_comb begin
    result_d = '0;
    case (cntrl)
      OP_PASS_B: result_d = B;
      OP_ADD:    result_d = sum;
      OP_SUB:    result_d = sum;
      OP_AND:    result_d = A & B;
      OP_OR:     result_d = A | B;
      OP_XOR:    result_d = A ^ B;
      default:   result_d = '0;
    endcase
  end

  assign overflow_d = is_arith & (carry_into_msb ^ sum_carry);
  assign carry_d    = is_arith & sum_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b1;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      result    <= result_d;
      negative  <= result_d[WIDTH-1];
      zero      <= ~|result_d;
      overflow  <= overflow_d;
      carry_out <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases, reset behaviour and
// randomized operations compared against an arithmetic reference model.
module tb_alu_core;

  localparam int W  = 64;
  localparam int EW = W + 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   cntrl;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  logic [EW-1:0] exp_q[$];
  int total;
  int bad;

  alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a),
    .B         (b),
    .cntrl     (cntrl),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected {result, n, z, v, c} from plain arithmetic.
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [2:0] op);
    logic [W-1:0] r;
    logic         v;
    logic         c;
    logic [W:0]   uwide;
    logic signed [W:0] swide;
    r = '0;
    v = 1'b0;
    c = 1'b0;
    case (op)
      3'b000: r = y;
      3'b010: begin
        uwide = {1'b0, x} + {1'b0, y};
        r     = uwide[W-1:0];
        c     = uwide[W];
        swide = $signed({x[W-1], x}) + $signed({y[W-1], y});
        v     = (swide > $signed({2'b00, {(W-1){1'b1}}})) ||
                (swide < $signed({2'b11, {(W-1){1'b0}}}));
      end
      3'b011: begin
        r     = x - y;
        c     = (x >= y);
        swide = $signed({x[W-1], x}) - $signed({y[W-1], y});
        v     = (swide > $signed({2'b00, {(W-1){1'b1}}})) ||
                (swide < $signed({2'b11, {(W-1){1'b0}}}));
      end
      3'b100: r = x & y;
      3'b101: r = x | y;
      3'b110: r = x ^ y;
      default: r = '0;
    endcase
    return {r, r[W-1], (r == '0), v, c};
  endfunction

  task automatic check_outputs(input string tag, input logic [EW-1:0] e);
    check({tag, ".result"}, result, e[EW-1:4]);
    check({tag, ".n"}, W'(negative),  W'(e[3]));
    check({tag, ".z"}, W'(zero),      W'(e[2]));
    check({tag, ".v"}, W'(overflow),  W'(e[1]));
    check({tag, ".c"}, W'(carry_out), W'(e[0]));
  endtask

  task automatic check_reset_values(input string tag);
    check_outputs(tag, {{W{1'b0}}, 4'b0100});
  endtask

  // Driver: apply one op between edges, then check the registered outputs after the edge.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [2:0] op);
    logic [EW-1:0] e;
    @(negedge clk);
    a     = x;
    b     = y;
    cntrl = op;
    exp_q.push_back(model(x, y, op));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = '1;
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = {1'b0, {(W-1){1'b1}}};
      4: v = W'($urandom_range(0, 15));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  localparam logic [W-1:0] MIN_S = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_S = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONES  = {W{1'b1}};

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = {$urandom, $urandom};
    b     = {$urandom, $urandom};
    cntrl = 3'b010;

    // Reset held across edges with arbitrary inputs
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_hold");
    rst_n = 1'b1;

    // Directed corner cases
    do_op("pass_b_neg",  64'h1234, MIN_S, 3'b000);
    do_op("pass_b_zero", 64'h1234, '0,    3'b000);
    do_op("add_ovf",     MAX_S, 64'd1, 3'b010);
    do_op("add_wrap",    ONES,  64'd1, 3'b010);
    do_op("sub_eq",      64'd5, 64'd5, 3'b011);
    do_op("sub_5_3",     64'd5, 64'd3, 3'b011);
    do_op("sub_3_5",     64'd3, 64'd5, 3'b011);
    do_op("sub_min_1",   MIN_S, 64'd1, 3'b011);
    do_op("and",         64'hF0F0, 64'hFF00, 3'b100);
    do_op("or",          64'hF0F0, 64'hFF00, 3'b101);
    do_op("xor",         64'hF0F0, 64'hFF00, 3'b110);
    do_op("and_disj",    64'h00FF, 64'hFF00, 3'b100);
    do_op("rsv_001",     ONES, ONES, 3'b001);
    do_op("rsv_111",     MIN_S, 64'd7, 3'b111);

    // Asynchronous reset mid-operation, then recovery on the first edge
    do_op("pre_reset", MAX_S, ONES, 3'b011);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_reset", 64'h10, 64'h20, 3'b010);

    // Random per opcode
    for (int op = 0; op < 8; op++) begin
      for (int i = 0; i < 1000; i++) begin
        do_op($sformatf("rand_op%0d", op), rand_operand(), rand_operand(), 3'(op));
      end
    end

    // Random opcode every cycle
    for (int i = 0; i < 1000; i++) begin
      do_op("rand_mix", rand_operand(), rand_operand(), 3'($urandom_range(0, 7)));
    end

    check("queue_drained", W'(exp_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
